// File: rtl/symbol_interleaver.sv
// Ping-pong block interleaver / deinterleaver for W-bit channel symbols.
// A ROWS x COLS matrix is filled in one order and drained in the transposed
// order. MODE=0 writes row-major and reads column-major (TX interleave).
// MODE=1 writes column-major and reads row-major (RX deinterleave).
// There are two banks. One fills while the other drains, so a continuous
// input stream produces a continuous output stream.
module symbol_interleaver #(
  parameter int W    = 2,
  parameter int ROWS = 4,
  parameter int COLS = 8,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] d_in,
  input  logic         flush_i,
  output logic         valid_o,
  output logic [W-1:0] d_out,
  output logic         blk_start_o,
  output logic         drop_o,
  output logic         busy_o
);

  localparam int BLK = ROWS * COLS;
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int NW  = $clog2(BLK + 1);
  localparam int IW  = $clog2(2 * BLK);

  typedef enum logic {WR_FILL, WR_PAD}  wr_state_t;
  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  // Write side state
  wr_state_t       wr_state_q, wr_state_d;
  logic [RW-1:0]   wr_row_q, wr_row_d;
  logic [CW-1:0]   wr_col_q, wr_col_d;
  logic [NW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            wr_bank_q, wr_bank_d;
  logic            drop_q, drop_d;
  logic            wr_en;
  logic [W-1:0]    wr_data;
  logic            blk_done;
  logic [IW-1:0]   wr_idx;

  // Read side state
  rd_state_t       rd_state_q, rd_state_d;
  logic [RW-1:0]   rd_row_q, rd_row_d;
  logic [CW-1:0]   rd_col_q, rd_col_d;
  logic            rd_bank_q, rd_bank_d;
  logic            emit;
  logic            sel_bank;
  logic [RW-1:0]   sel_row;
  logic [CW-1:0]   sel_col;
  logic [IW-1:0]   rd_idx;
  logic [W-1:0]    rd_data;

  // Registered outputs
  logic            valid_q;
  logic [W-1:0]    dout_q;
  logic            start_q;
  logic            busy_q;

  // Symbol storage for both banks. It is deliberately not reset. A bank is
  // only read after a whole block has been written into it.
  logic [W-1:0]    mem_q [2*BLK];

  assign wr_idx  = IW'(wr_bank_q) * IW'(BLK) + IW'(wr_row_q) * IW'(COLS) + IW'(wr_col_q);
  assign rd_idx  = IW'(sel_bank) * IW'(BLK) + IW'(sel_row) * IW'(COLS) + IW'(sel_col);
  assign rd_data = mem_q[rd_idx];

  // Write FSM: accept real symbols in FILL, or generate zero pads in PAD.
  // Advance the write position and hand the bank over once it is full.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    drop_d     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    blk_done   = 1'b0;

    case (wr_state_q)
      WR_FILL: begin
        if (valid_i) begin
          wr_en   = 1'b1;
          wr_data = d_in;
        end
        if (flush_i && (wr_cnt_q != '0)) begin
          wr_state_d = WR_PAD;
        end
      end
      WR_PAD: begin
        wr_en  = 1'b1;
        drop_d = valid_i;
      end
      default: wr_state_d = WR_FILL;
    endcase

    if (wr_en) begin
      if (wr_cnt_q == NW'(BLK - 1)) begin
        blk_done   = 1'b1;
        wr_row_d   = '0;
        wr_col_d   = '0;
        wr_cnt_d   = '0;
        wr_bank_d  = ~wr_bank_q;
        wr_state_d = WR_FILL;
      end else begin
        wr_cnt_d = wr_cnt_q + NW'(1);
        if (MODE == 0) begin
          if (wr_col_q == CW'(COLS - 1)) begin
            wr_col_d = '0;
            wr_row_d = wr_row_q + RW'(1);
          end else begin
            wr_col_d = wr_col_q + CW'(1);
          end
        end else begin
          if (wr_row_q == RW'(ROWS - 1)) begin
            wr_row_d = '0;
            wr_col_d = wr_col_q + CW'(1);
          end else begin
            wr_row_d = wr_row_q + RW'(1);
          end
        end
      end
    end
  end

  // Write FSM registers, including the delayed drop indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_FILL;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      drop_q     <= drop_d;
    end
  end

  // Bank storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Read FSM: on a completed block, emit position 0 from the just-filled bank
  // in the same cycle, then walk the transposed order one symbol per cycle.
  // A block completing on the final read restarts the walk on the new bank.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_row_d   = rd_row_q;
    rd_col_d   = rd_col_q;
    rd_bank_d  = rd_bank_q;
    emit       = 1'b0;
    sel_bank   = rd_bank_q;
    sel_row    = rd_row_q;
    sel_col    = rd_col_q;

    case (rd_state_q)
      RD_IDLE: begin
        if (blk_done) begin
          emit       = 1'b1;
          sel_bank   = wr_bank_q;
          sel_row    = '0;
          sel_col    = '0;
          rd_bank_d  = wr_bank_q;
          rd_state_d = RD_READ;
        end
      end
      RD_READ: emit = 1'b1;
      default: rd_state_d = RD_IDLE;
    endcase

    if (emit) begin
      if ((sel_row == RW'(ROWS - 1)) && (sel_col == CW'(COLS - 1))) begin
        rd_row_d = '0;
        rd_col_d = '0;
        if (blk_done && (rd_state_q == RD_READ)) begin
          rd_bank_d  = wr_bank_q;
          rd_state_d = RD_READ;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end else if (MODE == 0) begin
        if (sel_row == RW'(ROWS - 1)) begin
          rd_row_d = '0;
          rd_col_d = sel_col + CW'(1);
        end else begin
          rd_row_d = sel_row + RW'(1);
          rd_col_d = sel_col;
        end
      end else begin
        if (sel_col == CW'(COLS - 1)) begin
          rd_col_d = '0;
          rd_row_d = sel_row + RW'(1);
        end else begin
          rd_col_d = sel_col + CW'(1);
          rd_row_d = sel_row;
        end
      end
    end
  end

  // Read FSM registers and the registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      rd_bank_q  <= 1'b0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      rd_bank_q  <= rd_bank_d;
      valid_q    <= emit;
      dout_q     <= emit ? rd_data : '0;
      start_q    <= emit && (sel_row == '0) && (sel_col == '0);
      busy_q     <= emit;
    end
  end

  assign valid_o     = valid_q;
  assign d_out       = dout_q;
  assign blk_start_o = start_q;
  assign drop_o      = drop_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_symbol_interleaver.sv
// Scoreboard bench for symbol_interleaver.
// Instance A is the 5-bit TX, instance B is the 5-bit RX, and T/R are a 2-bit
// TX->RX chain with a burst-flip channel between them.
module tb_symbol_interleaver;

  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int BLK  = ROWS * COLS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       aValid = 0, aFlush = 0, aValidO, aStart, aDrop, aBusy;
  logic [4:0] aDin = '0, aDout;
  logic       bValid = 0, bFlush = 0, bValidO, bStart, bDrop, bBusy;
  logic [4:0] bDin = '0, bDout;
  logic       tValid = 0, tFlush = 0, tValidO, tStart, tDrop, tBusy;
  logic [1:0] tDin = '0, tDout;
  logic       rValidO, rStart, rDrop, rBusy;
  logic [1:0] rDin, rDout;
  logic       flipEn = 0;
  int         chCnt;

  symbol_interleaver #(.W(5), .ROWS(ROWS), .COLS(COLS), .MODE(0)) dutA (
    .clk(clk), .rst(rst), .valid_i(aValid), .d_in(aDin), .flush_i(aFlush),
    .valid_o(aValidO), .d_out(aDout), .blk_start_o(aStart), .drop_o(aDrop), .busy_o(aBusy));

  symbol_interleaver #(.W(5), .ROWS(ROWS), .COLS(COLS), .MODE(1)) dutB (
    .clk(clk), .rst(rst), .valid_i(bValid), .d_in(bDin), .flush_i(bFlush),
    .valid_o(bValidO), .d_out(bDout), .blk_start_o(bStart), .drop_o(bDrop), .busy_o(bBusy));

  symbol_interleaver #(.W(2), .ROWS(ROWS), .COLS(COLS), .MODE(0)) dutT (
    .clk(clk), .rst(rst), .valid_i(tValid), .d_in(tDin), .flush_i(tFlush),
    .valid_o(tValidO), .d_out(tDout), .blk_start_o(tStart), .drop_o(tDrop), .busy_o(tBusy));

  symbol_interleaver #(.W(2), .ROWS(ROWS), .COLS(COLS), .MODE(1)) dutR (
    .clk(clk), .rst(rst), .valid_i(tValidO), .d_in(rDin), .flush_i(1'b0),
    .valid_o(rValidO), .d_out(rDout), .blk_start_o(rStart), .drop_o(rDrop), .busy_o(rBusy));

  // Channel: two bursts of length 2 at channel positions 5,6 and 11,12
  assign rDin = tDout ^ ((flipEn && (chCnt == 5 || chCnt == 6 || chCnt == 11 || chCnt == 12)) ? 2'b11 : 2'b00);

  // Channel symbol counter for the TX->RX chain
  always @(posedge clk or posedge rst) begin
    if (rst) chCnt <= 0;
    else if (tValidO) chCnt <= chCnt + 1;
  end

  typedef struct packed {
    logic [4:0] d;
    logic       s;
  } expT;

  expT        qA[$], qB[$], qR[$];
  logic [1:0] origR[$];
  int         errIdx[$];
  int         checks = 0, errors = 0;
  int         countA = 0, firstA = 0, lastA = 0, dropA = 0, lastInA = 0;
  int         countB = 0, countR = 0, idxR = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int dut, input logic v, input logic [4:0] d, input logic f);
    @(negedge clk);
    case (dut)
      0: begin aValid = v; aDin = d; aFlush = f; if (v) lastInA = cyc; end
      1: begin bValid = v; bDin = d; bFlush = f; end
      default: begin tValid = v; tDin = d[1:0]; tFlush = f; end
    endcase
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((qA.size() + qB.size() + qR.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) checkOutput("drain_timeout", 32'(qA.size() + qB.size() + qR.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor A: compare each emitted symbol with the head of its queue, and
  // keep run statistics for the latency and continuity checks
  always @(negedge clk) begin : monA
    expT e;
    if (aDrop) dropA++;
    if (aValidO) begin
      if (countA == 0) firstA = cyc;
      lastA = cyc;
      countA++;
      if (qA.size() == 0) checkOutput("a_unexpected_valid", 1, 0);
      else begin
        e = qA.pop_front();
        checkOutput("a_data", 32'(aDout), 32'(e.d));
        checkOutput("a_blk_start", 32'(aStart), 32'(e.s));
        checkOutput("a_busy", 32'(aBusy), 1);
      end
    end else if (!rst) begin
      checkOutput("a_idle_outputs", 32'({aBusy, aStart, aDout}), 0);
    end
  end

  // Monitor B: deinterleaver output scoreboard
  always @(negedge clk) begin : monB
    expT e;
    if (bValidO) begin
      countB++;
      if (qB.size() == 0) checkOutput("b_unexpected_valid", 1, 0);
      else begin
        e = qB.pop_front();
        checkOutput("b_data", 32'(bDout), 32'(e.d));
        checkOutput("b_blk_start", 32'(bStart), 32'(e.s));
      end
    end
  end

  // Monitor R: chain output scoreboard. Also records every output index that
  // differs from the original data, for the burst-spacing check.
  always @(negedge clk) begin : monR
    expT        e;
    logic [1:0] o;
    if (rValidO) begin
      countR++;
      if (qR.size() == 0 || origR.size() == 0) checkOutput("r_unexpected_valid", 1, 0);
      else begin
        e = qR.pop_front();
        o = origR.pop_front();
        checkOutput("r_data", 32'(rDout), 32'(e.d));
        checkOutput("r_blk_start", 32'(rStart), 32'(e.s));
        if (rDout != o) errIdx.push_back(idxR);
      end
      idxR++;
    end
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    logic [4:0] blk [96];
    logic [4:0] real6 [6];
    logic [1:0] rnd [32];
    int         n;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_a_outputs", 32'({aValidO, aDout, aStart, aDrop, aBusy}), 0);
    checkOutput("reset_b_outputs", 32'({bValidO, bDout, bStart, bDrop, bBusy}), 0);
    checkOutput("reset_r_outputs", 32'({rValidO, rDout, rStart, rDrop, rBusy}), 0);
    rst = 1'b0;

    // Interleave 0..31: output j is row j%4, column j/4 of the row-major fill
    $display("[TB] interleave one block");
    countA = 0;
    for (int j = 0; j < BLK; j++) qA.push_back('{d: 5'((j % 4) * 8 + j / 4), s: (j == 0)});
    for (int i = 0; i < BLK; i++) applyStimulus(0, 1'b1, 5'(i), 1'b0);
    applyStimulus(0, 1'b0, 5'd0, 1'b0);
    waitDrain(100);
    checkOutput("a_first_output_latency", 32'(firstA - lastInA), 1);
    checkOutput("a_block_count", 32'(countA), 32);

    // Deinterleave the scrambled order back into 0..31
    $display("[TB] deinterleave one block");
    countB = 0;
    for (int j = 0; j < BLK; j++) qB.push_back('{d: 5'(j), s: (j == 0)});
    for (int k = 0; k < BLK; k++) applyStimulus(1, 1'b1, 5'((k % 4) * 8 + k / 4), 1'b0);
    applyStimulus(1, 1'b0, 5'd0, 1'b0);
    waitDrain(100);
    checkOutput("b_block_count", 32'(countB), 32);

    // Three back-to-back blocks must produce a gap-free 96-symbol stream
    $display("[TB] three continuous blocks");
    countA = 0;
    for (int i = 0; i < 96; i++) blk[i] = 5'((i * 7 + 3) % 32);
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < BLK; j++)
        qA.push_back('{d: blk[b * BLK + (j % 4) * 8 + j / 4], s: (j == 0)});
    for (int i = 0; i < 96; i++) applyStimulus(0, 1'b1, blk[i], 1'b0);
    applyStimulus(0, 1'b0, 5'd0, 1'b0);
    waitDrain(150);
    checkOutput("a_stream_count", 32'(countA), 96);
    checkOutput("a_stream_span", 32'(lastA - firstA), 95);

    // A flush on an empty block must not release anything
    $display("[TB] flush on empty block");
    countA = 0;
    applyStimulus(0, 1'b0, 5'd0, 1'b1);
    applyStimulus(0, 1'b0, 5'd0, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("a_empty_flush_quiet", 32'(countA), 0);

    // Flush after 6 real symbols: the rest of the block is zero padded and
    // 3 symbols offered during padding are dropped
    $display("[TB] partial block flush");
    countA = 0;
    dropA  = 0;
    real6 = '{5'd17, 5'd3, 5'd30, 5'd9, 5'd22, 5'd11};
    for (int j = 0; j < BLK; j++)
      qA.push_back('{d: ((j % 4 == 0) && (j / 4 < 6)) ? real6[j / 4] : 5'd0, s: (j == 0)});
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, real6[i], 1'b0);
    applyStimulus(0, 1'b1, real6[5], 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 5'd31, 1'b0);
    applyStimulus(0, 1'b0, 5'd0, 1'b0);
    waitDrain(100);
    checkOutput("a_drop_pulses", 32'(dropA), 3);
    checkOutput("a_padded_count", 32'(countA), 32);

    // Reset in the middle of reading a block
    $display("[TB] reset mid-read");
    countA = 0;
    for (int j = 0; j < BLK; j++) qA.push_back('{d: 5'((j % 4) * 8 + j / 4), s: (j == 0)});
    for (int i = 0; i < BLK; i++) applyStimulus(0, 1'b1, 5'(i), 1'b0);
    applyStimulus(0, 1'b0, 5'd0, 1'b0);
    n = 0;
    while (countA < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("a_reset_wait_timeout", 32'(countA), 10);
    #2 rst = 1'b1;
    qA.delete();
    #1;
    checkOutput("a_rst_valid", 32'(aValidO), 0);
    checkOutput("a_rst_outputs", 32'({aDout, aStart, aBusy}), 0);
    @(negedge clk);
    rst = 1'b0;
    countA = 0;
    repeat (100) @(negedge clk);
    checkOutput("a_post_reset_quiet", 32'(countA), 0);

    // TX->RX round trip with two length-2 bursts in the channel. Channel
    // positions 5,6,11,12 map back to output indices 9,17,26,3.
    $display("[TB] chained round trip with bursts");
    countR = 0;
    idxR   = 0;
    errIdx.delete();
    flipEn = 1'b1;
    for (int k = 0; k < BLK; k++) begin
      rnd[k] = 2'($urandom_range(0, 3));
      origR.push_back(rnd[k]);
      qR.push_back('{d: {3'b000, rnd[k] ^ ((k == 3 || k == 9 || k == 17 || k == 26) ? 2'b11 : 2'b00)}, s: (k == 0)});
    end
    for (int k = 0; k < BLK; k++) applyStimulus(2, 1'b1, {3'b000, rnd[k]}, 1'b0);
    applyStimulus(2, 1'b0, 5'd0, 1'b0);
    waitDrain(200);
    checkOutput("r_block_count", 32'(countR), 32);
    checkOutput("r_error_count", 32'(errIdx.size()), 4);
    for (int i = 1; i < errIdx.size(); i++)
      checkOutput("r_burst_spacing", 32'(errIdx[i] - errIdx[i - 1] >= ROWS), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
